// File: rtl/ads8528_emulator.sv
// ADS8528 parallel-interface slave model: per-pair conversions, busy timing, read-out of results.
// Optional protocol-violation counter is built when ADS8528_EMU_VIOLATION_CNT_EN is defined.
module ads8528_emulator #(
  parameter int DATA_WIDTH  = 16,
  parameter int CONV_CYCLES = 66
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [8*DATA_WIDTH-1:0] sample_in,
  input  logic                    reset,
  inout  wire  [DATA_WIDTH-1:0]   databits,
  input  logic                    read_n,
  input  logic                    write_n,
  input  logic                    chipselect_n,
  input  logic                    hardware_mode_n,
  input  logic                    parallel_mode_n,
  input  logic                    standby_n,
  input  logic                    range_xclock,
  input  logic                    conv_start_a,
  input  logic                    conv_start_b,
  input  logic                    conv_start_c,
  input  logic                    conv_start_d,
  output logic                    busy,
  output logic                    mode_error,
  output logic [7:0]              violation_count
);

  // state  | meaning
  // S_IDLE | no conversion running; reads are serviced
  // S_CONV | conversion running, busy=1, cnt counts down to terminal count 0

  localparam int CNT_W = 10;

  typedef enum logic {S_IDLE = 1'b0, S_CONV = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic [3:0] conv_start;
  logic [3:0] conv_prev;
  logic       read_n_prev;
  logic [3:0] conv_rise;
  logic       read_fall;

  logic mode_pins_bad;
  logic mode_ok;
  logic in_idle;
  logic in_conv;
  logic start_ok;
  logic read_edge;
  logic read_hit;
  logic commit;

  logic [DATA_WIDTH-1:0] pending [8];
  logic [DATA_WIDTH-1:0] result  [8];
  logic [3:0]            conv_mask;
  logic [2:0]            ptr;
  logic [DATA_WIDTH-1:0] out_reg;
  logic                  rd_active;
  logic                  bus_drive;

  logic unused_inputs;
  assign unused_inputs = ^{write_n, range_xclock};

  assign conv_start = {conv_start_d, conv_start_c, conv_start_b, conv_start_a};

  // History flops track the pins every cycle, including during reset, so they
  // already hold the current levels when reset releases.
  always_ff @(posedge clk) begin
    conv_prev   <= conv_start;
    read_n_prev <= read_n;
  end

  assign conv_rise = conv_start & ~conv_prev;
  assign read_fall = ~read_n & read_n_prev;

  assign mode_pins_bad = hardware_mode_n | parallel_mode_n;
  assign mode_ok       = ~mode_error & ~mode_pins_bad;
  assign in_idle       = (state == S_IDLE);
  assign in_conv       = (state == S_CONV);
  assign start_ok      = in_idle & standby_n & mode_ok & (|conv_rise);
  assign read_edge     = read_fall & ~chipselect_n;
  assign read_hit      = read_edge & mode_ok;
  assign commit        = in_conv & ~reset & standby_n & (cnt == '0);

  assign busy = in_conv;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (reset) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            state_nxt = S_CONV;
            cnt_nxt   = CNT_W'(CONV_CYCLES - 1);
          end
        end
        S_CONV: begin
          if (!standby_n) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
          end else if (cnt == '0) begin
            state_nxt = S_IDLE;
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
        default: begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 8; k++) begin
        pending[k] <= '0;
        result[k]  <= '0;
      end
      conv_mask  <= '0;
      ptr        <= '0;
      out_reg    <= '0;
      rd_active  <= 1'b0;
      mode_error <= 1'b0;
    end else if (reset) begin
      for (int k = 0; k < 8; k++) begin
        pending[k] <= '0;
        result[k]  <= '0;
      end
      conv_mask  <= '0;
      ptr        <= '0;
      out_reg    <= '0;
      rd_active  <= 1'b0;
      mode_error <= 1'b0;
    end else begin
      if (start_ok) begin
        conv_mask <= conv_rise;
        for (int p = 0; p < 4; p++) begin
          if (conv_rise[p]) begin
            pending[2*p]   <= sample_in[(2*p)*DATA_WIDTH +: DATA_WIDTH];
            pending[2*p+1] <= sample_in[(2*p+1)*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end

      // A read edge landing on a busy cycle presents 0 without moving the pointer.
      if (read_hit) begin
        if (in_idle) begin
          out_reg <= result[ptr];
          ptr     <= ptr + 3'd1;
        end else begin
          out_reg <= '0;
        end
      end

      if (commit) begin
        for (int p = 0; p < 4; p++) begin
          if (conv_mask[p]) begin
            result[2*p]   <= pending[2*p];
            result[2*p+1] <= pending[2*p+1];
          end
        end
        conv_mask <= '0;
        ptr       <= '0;
      end else if (in_conv && !standby_n) begin
        conv_mask <= '0;
      end

      if (read_hit) begin
        rd_active <= 1'b1;
      end else if (read_n || chipselect_n) begin
        rd_active <= 1'b0;
      end

      if (mode_pins_bad) begin
        mode_error <= 1'b1;
      end
    end
  end

  assign bus_drive = rd_active & ~chipselect_n & ~read_n & ~mode_error;
  assign databits  = bus_drive ? out_reg : {DATA_WIDTH{1'bz}};

`ifdef ADS8528_EMU_VIOLATION_CNT_EN
  logic       cs_n_prev;
  logic       viol_conv;
  logic       viol_read;
  logic       viol_cs;
  logic [1:0] viol_inc;
  logic [8:0] viol_sum;
  logic [7:0] viol_cnt;

  always_ff @(posedge clk) begin
    cs_n_prev <= chipselect_n;
  end

  assign viol_conv = in_conv & (|conv_rise);
  assign viol_read = in_conv & read_edge;
  assign viol_cs   = chipselect_n & ~cs_n_prev & ~read_n;
  assign viol_inc  = {1'b0, viol_conv} + {1'b0, viol_read} + {1'b0, viol_cs};
  assign viol_sum  = {1'b0, viol_cnt} + {7'd0, viol_inc};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      viol_cnt <= '0;
    end else if (reset) begin
      viol_cnt <= '0;
    end else if (viol_sum[8]) begin
      viol_cnt <= 8'hff;
    end else begin
      viol_cnt <= viol_sum[7:0];
    end
  end

  assign violation_count = viol_cnt;
`else
  assign violation_count = 8'd0;
`endif

endmodule

// File: tb/tb_ads8528_emulator.sv
// Directed bench for ads8528_emulator: conversion timing, partial conversions, pointer wrap,
// busy-time violations, standby abort, device reset and mode error.
module tb_ads8528_emulator;
  localparam int DW   = 16;
  localparam int CONV = 66;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            reset = 1'b0;
  logic [8*DW-1:0] sample_in = '0;
  logic            read_n = 1'b1;
  logic            write_n = 1'b1;
  logic            chipselect_n = 1'b0;
  logic            hardware_mode_n = 1'b0;
  logic            parallel_mode_n = 1'b0;
  logic            standby_n = 1'b1;
  logic            range_xclock = 1'b0;
  logic [3:0]      cs_start = 4'h0;
  tri1  [DW-1:0]   databits;
  logic            busy;
  logic            mode_error;
  logic [7:0]      violation_count;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  ads8528_emulator #(.DATA_WIDTH(DW), .CONV_CYCLES(CONV)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .sample_in(sample_in),
    .reset(reset),
    .databits(databits),
    .read_n(read_n),
    .write_n(write_n),
    .chipselect_n(chipselect_n),
    .hardware_mode_n(hardware_mode_n),
    .parallel_mode_n(parallel_mode_n),
    .standby_n(standby_n),
    .range_xclock(range_xclock),
    .conv_start_a(cs_start[0]),
    .conv_start_b(cs_start[1]),
    .conv_start_c(cs_start[2]),
    .conv_start_d(cs_start[3]),
    .busy(busy),
    .mode_error(mode_error),
    .violation_count(violation_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_samples(input logic [DW-1:0] base);
    for (int k = 0; k < 8; k++) sample_in[k*DW +: DW] = base + DW'(k);
  endtask

  // Leaves the bench in the first busy cycle (cycle t+1).
  task automatic start_conv(input logic [3:0] mask);
    cs_start = mask;
    step();
    cs_start = 4'h0;
  endtask

  // Advances until busy is low; returns the index of the first idle cycle.
  task automatic run_busy(input int start_idx, output int idle_idx);
    int idx = start_idx;
    while (busy && idx < 400) begin
      step();
      idx++;
    end
    idle_idx = idx;
  endtask

  task automatic do_read(output logic [DW-1:0] v);
    read_n = 1'b0;
    step();
    @(negedge clk);
    v = databits;
    @(posedge clk);
    #1;
    read_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    logic [DW-1:0] v;
    repeat (3) @(posedge clk);
    #1;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
    n_total++; if (mode_error !== 1'b0) $display("FAIL reset_mode_error: got %b expected 0", mode_error); else n_pass++;
    n_total++; if (violation_count !== 8'd0) $display("FAIL reset_viol: got %0d expected 0", violation_count); else n_pass++;
    n_total++; if (databits !== {DW{1'b1}}) $display("FAIL reset_bus_z: got %h expected undriven ffff", databits); else n_pass++;
    reset_n = 1'b1;
    step();
    step();
    do_read(v);
    n_total++; if (v !== 16'h0000) $display("FAIL reset_result: got %h expected 0000", v); else n_pass++;
  endtask

  task automatic test_full_conv();
    logic [DW-1:0] v;
    int idle_idx;
    set_samples(16'h1000);
    cs_start = 4'hF;
    n_total++; if (busy !== 1'b0) $display("FAIL full_busy_edge_cycle: got %b expected 0", busy); else n_pass++;
    step();
    cs_start = 4'h0;
    n_total++; if (busy !== 1'b1) $display("FAIL full_busy_next_cycle: got %b expected 1", busy); else n_pass++;
    run_busy(1, idle_idx);
    n_total++; if (idle_idx !== CONV + 1) $display("FAIL full_busy_length: got %0d expected %0d", idle_idx - 1, CONV); else n_pass++;
    for (int k = 0; k < 8; k++) begin
      do_read(v);
      n_total++; if (v !== 16'h1000 + DW'(k)) $display("FAIL full_read%0d: got %h expected %h", k, v, 16'h1000 + DW'(k)); else n_pass++;
    end
  endtask

  task automatic test_partial();
    logic [DW-1:0] v;
    logic [DW-1:0] exp;
    int idle_idx;
    set_samples(16'h2000);
    start_conv(4'b0010);
    run_busy(1, idle_idx);
    n_total++; if (idle_idx !== CONV + 1) $display("FAIL partial_busy_length: got %0d expected %0d", idle_idx - 1, CONV); else n_pass++;
    for (int k = 0; k < 8; k++) begin
      exp = (k == 2 || k == 3) ? 16'h2000 + DW'(k) : 16'h1000 + DW'(k);
      do_read(v);
      n_total++; if (v !== exp) $display("FAIL partial_read%0d: got %h expected %h", k, v, exp); else n_pass++;
    end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] v;
    logic [DW-1:0] exp;
    int idle_idx;
    set_samples(16'h3000);
    start_conv(4'hF);
    run_busy(1, idle_idx);
    n_total++; if (idle_idx !== CONV + 1) $display("FAIL wrap_busy_length: got %0d expected %0d", idle_idx - 1, CONV); else n_pass++;
    for (int k = 0; k < 10; k++) begin
      exp = 16'h3000 + DW'(k % 8);
      do_read(v);
      n_total++; if (v !== exp) $display("FAIL wrap_read%0d: got %h expected %h", k, v, exp); else n_pass++;
    end
  endtask

  task automatic test_busy_violations();
    logic [DW-1:0] v;
    logic [7:0] exp_viol;
    int idx;
    int idle_idx;
`ifdef ADS8528_EMU_VIOLATION_CNT_EN
    exp_viol = 8'd2;
`else
    exp_viol = 8'd0;
`endif
    set_samples(16'h4000);
    start_conv(4'hF);
    idx = 1;
    repeat (9) begin
      step();
      idx++;
    end
    set_samples(16'h5000);
    cs_start = 4'b0001;
    step();
    idx++;
    cs_start = 4'h0;
    read_n = 1'b0;
    step();
    idx++;
    @(negedge clk);
    v = databits;
    n_total++; if (v !== 16'h0000) $display("FAIL busy_read_bus: got %h expected 0000", v); else n_pass++;
    @(posedge clk);
    #1;
    idx++;
    read_n = 1'b1;
    run_busy(idx, idle_idx);
    n_total++; if (idle_idx !== CONV + 1) $display("FAIL busy_viol_length: got %0d expected %0d", idle_idx - 1, CONV); else n_pass++;
    n_total++; if (violation_count !== exp_viol) $display("FAIL viol_count: got %0d expected %0d", violation_count, exp_viol); else n_pass++;
    step();
    for (int k = 0; k < 8; k++) begin
      do_read(v);
      n_total++; if (v !== 16'h4000 + DW'(k)) $display("FAIL busy_viol_read%0d: got %h expected %h", k, v, 16'h4000 + DW'(k)); else n_pass++;
    end
  endtask

  task automatic test_standby();
    logic [DW-1:0] v;
    set_samples(16'h6000);
    start_conv(4'hF);
    repeat (19) step();
    n_total++; if (busy !== 1'b1) $display("FAIL standby_busy_c20: got %b expected 1", busy); else n_pass++;
    standby_n = 1'b0;
    step();
    n_total++; if (busy !== 1'b0) $display("FAIL standby_busy_drop: got %b expected 0", busy); else n_pass++;
    start_conv(4'hF);
    n_total++; if (busy !== 1'b0) $display("FAIL standby_start_blocked: got %b expected 0", busy); else n_pass++;
    step();
    standby_n = 1'b1;
    step();
    for (int k = 0; k < 8; k++) begin
      do_read(v);
      n_total++; if (v !== 16'h4000 + DW'(k)) $display("FAIL standby_read%0d: got %h expected %h", k, v, 16'h4000 + DW'(k)); else n_pass++;
    end
  endtask

  task automatic test_device_reset();
    logic [DW-1:0] v;
    set_samples(16'h7000);
    start_conv(4'hF);
    repeat (4) step();
    reset = 1'b1;
    step();
    n_total++; if (busy !== 1'b0) $display("FAIL dev_reset_busy: got %b expected 0", busy); else n_pass++;
    reset = 1'b0;
    step();
    do_read(v);
    n_total++; if (v !== 16'h0000) $display("FAIL dev_reset_result: got %h expected 0000", v); else n_pass++;
    start_conv(4'hF);
    repeat (3) step();
    reset_n = 1'b0;
    #1;
    n_total++; if (busy !== 1'b0) $display("FAIL async_reset_busy: got %b expected 0", busy); else n_pass++;
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_mode_error();
    parallel_mode_n = 1'b1;
    step();
    parallel_mode_n = 1'b0;
    n_total++; if (mode_error !== 1'b1) $display("FAIL mode_error_set: got %b expected 1", mode_error); else n_pass++;
    start_conv(4'hF);
    n_total++; if (busy !== 1'b0) $display("FAIL mode_error_busy: got %b expected 0", busy); else n_pass++;
    read_n = 1'b0;
    step();
    @(negedge clk);
    n_total++; if (databits !== {DW{1'b1}}) $display("FAIL mode_error_bus_z: got %h expected undriven ffff", databits); else n_pass++;
    @(posedge clk);
    #1;
    read_n = 1'b1;
    n_total++; if (mode_error !== 1'b1) $display("FAIL mode_error_sticky: got %b expected 1", mode_error); else n_pass++;
    step();
    reset_n = 1'b0;
    #1;
    n_total++; if (mode_error !== 1'b0) $display("FAIL mode_error_clear: got %b expected 0", mode_error); else n_pass++;
    step();
    reset_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_full_conv();
    test_partial();
    test_wrap();
    test_busy_violations();
    test_standby();
    test_device_reset();
    test_mode_error();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
